// File: rtl/fifo_nibble_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_nibble_serializer_pkg
//   Shared definitions for the FIFO-to-serial frame transmitter:
//   - FIFO mode command encodings understood by the 4-bit mode-controlled FIFO
//   - transmitter FSM state enumeration
//   - default data word width
// -----------------------------------------------------------------------------
package fifo_nibble_serializer_pkg;

    // Default width of one FIFO word and of the data field of a frame.
    localparam int DEF_DATA_W = 4;

    // FIFO mode commands. The serializer only ever issues IDLE or POP;
    // PUSH is listed so every user of the FIFO shares one encoding.
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_PUSH = 2'b01;
    localparam logic [1:0] MODE_POP  = 2'b10;

    // Transmitter FSM states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

endpackage : fifo_nibble_serializer_pkg

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//   Divides clk into serial bit periods of BAUD_DIV cycles.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     clr    in   holds the divider at the start of a period
//     tick   out  high on the last cycle of every BAUD_DIV-cycle period
//
//   While clr is high the counter sits at 0, so the first period after clr
//   drops is a full BAUD_DIV cycles long. With BAUD_DIV=1 tick is always high.
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    // Counter holds 0..BAUD_DIV-1; the extra headroom bit keeps the width
    // non-zero for BAUD_DIV=1.
    localparam int              CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            // Wrap at the period end; never counts past CNT_LAST.
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : baud_tick_gen

// File: rtl/fifo_nibble_serializer.sv
// -----------------------------------------------------------------------------
// fifo_nibble_serializer
//   Read-side consumer of the 4-bit mode-controlled FIFO. Pops one word at a
//   time and sends it as an asynchronous serial frame:
//     start (0) | DATA_W data bits, LSB first | even parity (optional) | stop (1)
//   Each bit lasts BAUD_DIV clk cycles.
//
//   Ports:
//     clk           in   system clock, rising edge
//     rst_n         in   asynchronous active-low reset
//     en            in   allows a new frame to start (does not abort one)
//     fifo_empty    in   FIFO empty flag (registered in the FIFO)
//     fifo_dataout  in   FIFO read data (registered in the FIFO)
//     fifo_mode     out  FIFO mode command, MODE_POP for one cycle per word
//     ser_out       out  serial line, idles at 1
//     busy          out  high whenever the FSM is not in IDLE
//     frame_done    out  one-cycle pulse in the first IDLE cycle after stop
//
//   Sequence per word: IDLE -> POP (pop edge) -> LOAD (capture edge) ->
//   START -> DATA x DATA_W -> [PARITY] -> STOP -> IDLE.
//   The FIFO's registered dataout is valid during LOAD, one cycle after the
//   pop edge, so it is captured at the edge that ends LOAD. Its empty flag
//   lags by a cycle too, but LOAD plus at least one bit period always
//   separate a pop from the next IDLE evaluation, so no extra guard is needed.
//   All outputs decode registered state only.
// -----------------------------------------------------------------------------
module fifo_nibble_serializer
    import fifo_nibble_serializer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BAUD_DIV  = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dataout,
    output logic [1:0]        fifo_mode,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    // Bit counter covers 0..DATA_W so the increment after the last data bit
    // cannot overflow.
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic              done_q;
    logic              tick;
    logic              baud_clr;

    // -------------------------------------------------------------------------
    // Bit-period timing
    // -------------------------------------------------------------------------
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && (bit_cnt == LAST_BIT)) begin
                    state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, parity, bit counter, frame-done flag
    // -------------------------------------------------------------------------
    // NOTE: the shift register is a handful of flops, not a memory array, so
    // it is reset along with the rest of the state to keep ser_out defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            // The pulse lands in the IDLE cycle that follows the stop bit.
            done_q <= (state == ST_STOP) && tick;

            if (state == ST_LOAD) begin
                shift_q  <= fifo_dataout;
                // Even parity: XOR of the data makes the total ones count even.
                parity_q <= ^fifo_dataout;
                bit_cnt  <= '0;
            end else if ((state == ST_DATA) && tick) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_mode = MODE_IDLE;
        ser_out   = 1'b1;
        busy      = 1'b1;
        baud_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                baud_clr = 1'b1;
            end
            ST_POP: begin
                fifo_mode = MODE_POP;
                baud_clr  = 1'b1;
            end
            ST_LOAD: begin
                // Divider is held here so START gets a full bit period.
                baud_clr = 1'b1;
            end
            ST_START: begin
                ser_out = 1'b0;
            end
            ST_DATA: begin
                ser_out = shift_q[0];
            end
            ST_PARITY: begin
                ser_out = parity_q;
            end
            ST_STOP: begin
                ser_out = 1'b1;
            end
            default: begin
                ser_out = 1'b1;
            end
        endcase
    end

    assign frame_done = done_q;

endmodule : fifo_nibble_serializer

// File: tb/tb_fifo_nibble_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_nibble_serializer
//   Two DUT instances: dut_a (BAUD_DIV=2, parity on) and dut_b (BAUD_DIV=1,
//   parity off), each fed by a small behavioural model of the mode-controlled
//   FIFO (registered dataout, registered empty flag). Outputs are sampled on
//   the falling edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_fifo_nibble_serializer;

    logic       clk = 1'b0;
    logic       rst_n;

    // dut_a side
    logic       en_a;
    logic       empty_a;
    logic [3:0] dout_a;
    logic [1:0] mode_a;
    logic       ser_a, busy_a, done_a;

    // dut_b side
    logic       empty_b;
    logic [3:0] dout_b;
    logic [1:0] mode_b;
    logic       ser_b, busy_b, done_b;

    // Selects which DUT the frame-checking tasks observe.
    logic       sel;
    logic       ser_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;
    int pops_a = 0;
    int pops_b = 0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 clk = ~clk;

    fifo_nibble_serializer #(.DATA_W(4), .BAUD_DIV(2), .PARITY_EN(1)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en_a),
        .fifo_empty   (empty_a),
        .fifo_dataout (dout_a),
        .fifo_mode    (mode_a),
        .ser_out      (ser_a),
        .busy         (busy_a),
        .frame_done   (done_a)
    );

    fifo_nibble_serializer #(.DATA_W(4), .BAUD_DIV(1), .PARITY_EN(0)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (1'b1),
        .fifo_empty   (empty_b),
        .fifo_dataout (dout_b),
        .fifo_mode    (mode_b),
        .ser_out      (ser_b),
        .busy         (busy_b),
        .frame_done   (done_b)
    );

    always_comb begin
        ser_m  = sel ? ser_b  : ser_a;
        busy_m = sel ? busy_b : busy_a;
        done_m = sel ? done_b : done_a;
    end

    // FIFO models: pop on mode 10, dataout and empty update at the edge.
    always @(posedge clk) begin
        if (mode_a == 2'b10) begin
            pops_a++;
            if (q_a.size() > 0) dout_a <= q_a.pop_front();
        end
        empty_a <= (q_a.size() == 0);
    end

    always @(posedge clk) begin
        if (mode_b == 2'b10) begin
            pops_b++;
            if (q_b.size() > 0) dout_b <= q_b.pop_front();
        end
        empty_b <= (q_b.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Poll on falling edges until the start bit appears; n is cycles waited.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (ser_m !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, {31'd0, ser_m}, 32'd0);
    endtask

    // Called on the first start-bit cycle; checks every cycle of the frame,
    // then returns on the frame_done cycle.
    task automatic check_frame(input string tag, input logic [7:0] bits,
                               input int nbits, input int div);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, b, c), {31'd0, ser_m}, {31'd0, bits[b]});
                check($sformatf("%s_busy%0d_c%0d", tag, b, c), {31'd0, busy_m}, 32'd1);
                @(negedge clk);
            end
        end
        check({tag, "_frame_done"}, {31'd0, done_m}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy_m}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] word;
        logic [7:0] frame;   // frame[0] is the first bit on the line
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int p0;

        // Frames for BAUD_DIV=2, even parity: start, d0..d3, parity, stop.
        vecs[0] = '{4'h7, 8'b0110_1110};
        vecs[1] = '{4'h0, 8'b0100_0000};
        vecs[2] = '{4'hF, 8'b0101_1110};
        vecs[3] = '{4'h1, 8'b0110_0010};
        vecs[4] = '{4'h6, 8'b0100_1100};

        sel     = 1'b0;
        rst_n   = 1'b0;
        en_a    = 1'b1;
        empty_a = 1'b1;
        dout_a  = '0;
        empty_b = 1'b1;
        dout_b  = '0;
        q_a.push_back(4'hA);

        // Reset held with data available and en=1: nothing may move.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_mode", {30'd0, mode_a}, 32'd0);
            check("rst_ser", {31'd0, ser_a}, 32'd1);
            check("rst_busy", {31'd0, busy_a}, 32'd0);
            check("rst_done", {31'd0, done_a}, 32'd0);
        end
        check("rst_no_pop", pops_a, 0);
        rst_n = 1'b1;

        // Single frame 4'hA; start bit 3 cycles after first IDLE evaluation.
        wait_start("single", n);
        check("single_latency", n, 3);
        check_frame("single", 8'b0101_0100, 7, 2);
        check("single_pops", pops_a, 1);
        @(negedge clk);
        check("single_done_pulse", {31'd0, done_a}, 32'd0);

        // Table of single-word frames.
        foreach (vecs[i]) begin
            p0 = pops_a;
            q_a.push_back(vecs[i].word);
            wait_start($sformatf("vec%0d", i), n);
            check_frame($sformatf("vec%0d", i), vecs[i].frame, 7, 2);
            check($sformatf("vec%0d_pops", i), pops_a - p0, 1);
            @(negedge clk);
            check($sformatf("vec%0d_done_low", i), {31'd0, done_a}, 32'd0);
        end

        // Back-to-back 4'h3 then 4'hC with a 3-cycle idle gap.
        p0 = pops_a;
        q_a.push_back(4'h3);
        q_a.push_back(4'hC);
        wait_start("b2b0", n);
        check_frame("b2b0", 8'b0100_0110, 7, 2);
        n = 0;
        while (ser_a === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap", n, 3);
        check_frame("b2b1", 8'b0101_1000, 7, 2);
        check("b2b_pops", pops_a - p0, 2);

        // en=0 with data waiting: no pop for 20 cycles.
        en_a = 1'b0;
        p0 = pops_a;
        q_a.push_back(4'h5);
        repeat (20) @(negedge clk);
        check("en0_no_pop", pops_a - p0, 0);
        check("en0_idle", {31'd0, busy_a}, 32'd0);

        // Drop en during DATA: frame completes, no second pop.
        q_a.push_back(4'h6);
        en_a = 1'b1;
        wait_start("endrop", n);
        fork
            begin
                repeat (3) @(negedge clk);
                en_a = 1'b0;
            end
        join_none
        check_frame("endrop", 8'b0100_1010, 7, 2);
        repeat (20) @(negedge clk);
        check("endrop_pops", pops_a - p0, 1);
        check("endrop_idle", {31'd0, busy_a}, 32'd0);
        en_a = 1'b1;
        wait_start("flush", n);
        check_frame("flush", 8'b0100_1100, 7, 2);
        check("flush_pops", pops_a - p0, 2);
        @(negedge clk);

        // Reset during the second data bit of 4'h9.
        p0 = pops_a;
        q_a.push_back(4'h9);
        wait_start("midrst", n);
        repeat (4) @(negedge clk);
        check("midrst_bit1", {31'd0, ser_a}, 32'd0);
        check("midrst_busy_pre", {31'd0, busy_a}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ser", {31'd0, ser_a}, 32'd1);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_mode", {30'd0, mode_a}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_pop", pops_a - p0, 1);
        check("midrst_idle_ser", {31'd0, ser_a}, 32'd1);
        q_a.push_back(4'hD);
        wait_start("postrst", n);
        check_frame("postrst", 8'b0111_1010, 7, 2);
        check("postrst_pops", pops_a - p0, 2);
        @(negedge clk);

        // dut_b: BAUD_DIV=1, no parity, word 4'hF -> 0,1,1,1,1,1 then done.
        sel = 1'b1;
        q_b.push_back(4'hF);
        wait_start("nopar", n);
        check_frame("nopar", 8'b0011_1110, 6, 1);
        check("nopar_pops", pops_b, 1);
        @(negedge clk);
        check("nopar_done_low", {31'd0, done_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_nibble_serializer
